// File: rtl/ln_row_packer.sv
// Row packer feeding the layernorm core: gathers a token row beat by beat
// and accumulates sum and sum-of-squares alongside.
module ln_row_packer #(
  parameter int INPUT_WIDTH = 8,
  parameter int INPUT_NUM   = 768,
  parameter int LANES       = 8,
  parameter int SUM_WIDTH   = INPUT_WIDTH + $clog2(INPUT_NUM),
  parameter int SQ_WIDTH    = 2*INPUT_WIDTH + $clog2(INPUT_NUM)
) (
  input  logic                               clk_p,
  input  logic                               rst_n,
  input  logic [INPUT_WIDTH*LANES-1:0]       in_data,
  input  logic                               in_valid_n,
  input  logic                               in_last,
  output logic                               in_ready_n,
  output logic [INPUT_WIDTH*INPUT_NUM-1:0]   row_data,
  output logic signed [SUM_WIDTH-1:0]        row_sum,
  output logic [SQ_WIDTH-1:0]                row_sqsum,
  output logic                               row_valid_n,
  input  logic                               row_ready_n,
  output logic                               err_frame
);

  localparam int W     = INPUT_WIDTH;
  localparam int BEATS = INPUT_NUM / LANES;
  localparam int BW    = W * LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t  state, state_nxt;
  logic [CW-1:0] cnt;
  logic    accept, xfer, last_beat;
  logic [BW-1:0] beat_mem [BEATS];

  logic signed [SUM_WIDTH-1:0] beat_sum;
  logic [SQ_WIDTH-1:0]         beat_sq;
  logic signed [W-1:0]         lane;
  logic signed [2*W-1:0]       lane_sq;

  assign in_ready_n  = !rst_n | (state == HOLD);
  assign row_valid_n = (state != HOLD);
  assign accept      = !in_valid_n && !in_ready_n;
  assign xfer        = (state == HOLD) && !row_ready_n;
  assign last_beat   = (cnt == LAST_CNT);

  // Per-beat partial sums; squares are non-negative so zero-extend them
  always_comb begin
    beat_sum = '0;
    beat_sq  = '0;
    lane     = '0;
    lane_sq  = '0;
    for (int j = 0; j < LANES; j++) begin
      lane     = in_data[j*W +: W];
      lane_sq  = lane * lane;
      beat_sum = beat_sum
               + {{(SUM_WIDTH-W){lane[W-1]}}, lane};
      beat_sq  = beat_sq
               + {{(SQ_WIDTH-2*W){1'b0}}, lane_sq};
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL: if (accept && last_beat) state_nxt = HOLD;
      HOLD: if (!row_ready_n) state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk_p) begin
    if (!rst_n) begin
      state     <= FILL;
      cnt       <= '0;
      row_sum   <= '0;
      row_sqsum <= '0;
      err_frame <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt       <= last_beat ? '0 : cnt + 1'b1;
        row_sum   <= row_sum + beat_sum;
        row_sqsum <= row_sqsum + beat_sq;
        if (in_last != last_beat) err_frame <= 1'b1;
      end else if (xfer) begin
        row_sum   <= '0;
        row_sqsum <= '0;
      end
    end
  end

  // Row storage is overwritten in place; never cleared between rows
  always_ff @(posedge clk_p) begin
    if (!rst_n) begin
      for (int b = 0; b < BEATS; b++) beat_mem[b] <= '0;
    end else if (accept) begin
      beat_mem[cnt] <= in_data;
    end
  end

  for (genvar b = 0; b < BEATS; b++) begin : g_pack
    assign row_data[b*BW +: BW] = beat_mem[b];
  end

endmodule

// File: tb/tb_ln_row_packer.sv
// Scoreboard bench for ln_row_packer with a 16-element, 8-lane row.
module tb_ln_row_packer;

  localparam int W  = 8;
  localparam int N  = 16;
  localparam int L  = 8;
  localparam int B  = N / L;
  localparam int SW = W + $clog2(N);
  localparam int QW = 2*W + $clog2(N);

  logic                 clk_p = 1'b0;
  logic                 rst_n;
  logic [L*W-1:0]       in_data;
  logic                 in_valid_n;
  logic                 in_last;
  logic                 in_ready_n;
  logic [N*W-1:0]       row_data;
  logic signed [SW-1:0] row_sum;
  logic [QW-1:0]        row_sqsum;
  logic                 row_valid_n;
  logic                 row_ready_n;
  logic                 err_frame;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N*W-1:0] data;
    int             sum;
    int             sq;
  } row_t;

  row_t q[$];

  ln_row_packer #(
    .INPUT_WIDTH(W),
    .INPUT_NUM  (N),
    .LANES      (L)
  ) dut (
    .clk_p      (clk_p),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid_n (in_valid_n),
    .in_last    (in_last),
    .in_ready_n (in_ready_n),
    .row_data   (row_data),
    .row_sum    (row_sum),
    .row_sqsum  (row_sqsum),
    .row_valid_n(row_valid_n),
    .row_ready_n(row_ready_n),
    .err_frame  (err_frame)
  );

  always #5 clk_p = ~clk_p;

  task automatic chk(input string nm,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: compares every presented row cycle, pops on transfer
  always @(negedge clk_p) begin
    if (rst_n === 1'b1 && row_valid_n === 1'b0) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_row: got valid row expected none");
      end else begin
        total++;
        if (row_data !== q[0].data) begin
          bad++;
          $display("FAIL row_data: got %h expected %h",
                   row_data, q[0].data);
        end
        chk("row_sum", $signed(row_sum), q[0].sum);
        chk("row_sqsum", {44'd0, row_sqsum}, q[0].sq);
        if (row_ready_n === 1'b0) void'(q.pop_front());
      end
    end
  end

  task automatic set_rdy(input logic v);
    @(posedge clk_p);
    #2 row_ready_n = v;
  endtask

  task automatic send_beat(input logic [L*W-1:0] d, input logic lst);
    int n;
    n = 0;
    @(negedge clk_p);
    in_valid_n = 1'b0;
    in_data    = d;
    in_last    = lst;
    while (in_ready_n !== 1'b0 && n < 200) begin
      @(negedge clk_p);
      n++;
    end
    if (n >= 200) chk("beat_accept_timeout", n, 0);
    @(posedge clk_p);
    #1 in_valid_n = 1'b1;
    in_last = 1'b0;
  endtask

  task automatic send_row(input int el[N], input int last_bits,
                          input int gap);
    row_t r;
    logic [L*W-1:0] d;
    logic [W-1:0] v;
    r.data = '0;
    r.sum  = 0;
    r.sq   = 0;
    for (int e = 0; e < N; e++) begin
      v = W'(el[e]);
      r.data[e*W +: W] = v;
      r.sum += el[e];
      r.sq  += el[e] * el[e];
    end
    q.push_back(r);
    for (int b = 0; b < B; b++) begin
      for (int j = 0; j < L; j++) d[j*W +: W] = W'(el[b*L+j]);
      send_beat(d, last_bits[b]);
      if (b < B-1) repeat (gap) @(negedge clk_p);
    end
  endtask

  initial begin
    int el[N];
    int n;
    logic [L*W-1:0] d;

    rst_n       = 1'b0;
    in_valid_n  = 1'b1;
    in_last     = 1'b0;
    in_data     = '0;
    row_ready_n = 1'b0;

    repeat (3) @(posedge clk_p);
    @(negedge clk_p);
    chk("rst_valid_n", row_valid_n, 1);
    chk("rst_ready_n", in_ready_n, 1);
    chk("rst_sum", $signed(row_sum), 0);
    chk("rst_sqsum", {44'd0, row_sqsum}, 0);
    chk("rst_err", err_frame, 0);
    chk("rst_data_zero", (row_data == '0), 1);
    rst_n = 1'b1;
    @(negedge clk_p);
    chk("ready_after_rst", in_ready_n, 0);

    // basic row 1..16
    for (int e = 0; e < N; e++) el[e] = e + 1;
    send_row(el, 2, 0);
    @(negedge clk_p);
    chk("basic_valid_low", row_valid_n, 0);
    chk("basic_sum", $signed(row_sum), 136);
    chk("basic_sqsum", {44'd0, row_sqsum}, 1496);
    chk("basic_err", err_frame, 0);
    @(negedge clk_p);
    chk("basic_valid_pulse", row_valid_n, 1);

    // signed extreme
    for (int e = 0; e < N; e++) el[e] = -128;
    send_row(el, 2, 0);
    @(negedge clk_p);
    chk("ext_sum", $signed(row_sum), -2048);
    chk("ext_sqsum", {44'd0, row_sqsum}, 262144);

    // backpressure with the next beat already offered
    set_rdy(1'b1);
    for (int e = 0; e < N; e++) el[e] = $urandom_range(255) - 128;
    send_row(el, 2, 0);
    in_valid_n = 1'b0;
    for (int j = 0; j < L; j++) d[j*W +: W] = W'(3*j - 7);
    in_data = d;
    repeat (5) begin
      @(negedge clk_p);
      chk("bp_ready_n", in_ready_n, 1);
      chk("bp_valid_n", row_valid_n, 0);
    end
    set_rdy(1'b0);
    for (int e = 0; e < N; e++) el[e] = (e < L) ? 3*e - 7 : e*e - 100;
    send_row(el, 2, 0);

    // bubbles, same content as basic row
    for (int e = 0; e < N; e++) el[e] = e + 1;
    send_row(el, 2, 3);
    @(negedge clk_p);
    chk("bubble_sum", $signed(row_sum), 136);
    chk("bubble_sqsum", {44'd0, row_sqsum}, 1496);

    // random rows
    for (int r = 0; r < 12; r++) begin
      for (int e = 0; e < N; e++) el[e] = $urandom_range(255) - 128;
      send_row(el, 2, $urandom_range(2));
    end
    @(negedge clk_p);
    chk("err_clean", err_frame, 0);

    // framing: in_last on beat 0 too
    for (int e = 0; e < N; e++) el[e] = $urandom_range(255) - 128;
    send_row(el, 3, 0);
    @(negedge clk_p);
    chk("frame_err_set", err_frame, 1);
    chk("frame_row_done", row_valid_n, 0);
    for (int e = 0; e < N; e++) el[e] = $urandom_range(255) - 128;
    send_row(el, 2, 1);
    @(negedge clk_p);
    chk("frame_err_sticky", err_frame, 1);

    // mid-stream reset discards the partial row
    for (int j = 0; j < L; j++) d[j*W +: W] = 8'h7f;
    send_beat(d, 1'b0);
    @(negedge clk_p);
    rst_n = 1'b0;
    repeat (3) @(posedge clk_p);
    @(negedge clk_p);
    chk("mid_rst_valid_n", row_valid_n, 1);
    chk("mid_rst_ready_n", in_ready_n, 1);
    chk("mid_rst_sum", $signed(row_sum), 0);
    chk("mid_rst_sqsum", {44'd0, row_sqsum}, 0);
    chk("mid_rst_err", err_frame, 0);
    rst_n = 1'b1;
    @(negedge clk_p);
    chk("mid_ready_after", in_ready_n, 0);
    for (int e = 0; e < N; e++) el[e] = $urandom_range(255) - 128;
    send_row(el, 2, 0);

    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk_p);
      n++;
    end
    chk("queue_drained", q.size(), 0);
    repeat (2) @(negedge clk_p);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ln_row_packer.md
# ln_row_packer

Streaming front-end for the per-token layernorm stage. Collects one token row of `INPUT_NUM` signed elements arriving `LANES` elements per beat and packs them into the flat row bus the layernorm core consumes (`data`, `data_valid_n`). While packing, it accumulates the row sum and the row sum-of-squares so mean and variance are ready when the row completes. It is a single-buffered fill/hold stage with active-low valid/ready handshakes on both sides.

## Interface
- `INPUT_WIDTH`, 8: element width, signed two's complement.
- `INPUT_NUM`, 768: elements per row; must be a multiple of `LANES`.
- `LANES`, 8: elements per input beat. BEATS = `INPUT_NUM`/`LANES`.
- `SUM_WIDTH`, `INPUT_WIDTH`+clog2(`INPUT_NUM`): signed row-sum width.
- `SQ_WIDTH`, 2*`INPUT_WIDTH`+clog2(`INPUT_NUM`): unsigned sum-of-squares width.

Ports:
- `clk_p` input 1: single clock, rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_data` input `INPUT_WIDTH`*`LANES`: beat payload; lane j is in bits [(j+1)*W-1 : j*W].
- `in_valid_n` input 1: beat valid, active-low.
- `in_last` input 1: source marks the final beat of a row.
- `in_ready_n` output 1: stage can accept a beat, active-low.
- `row_data` output `INPUT_WIDTH`*`INPUT_NUM`: packed row; element e is in bits [(e+1)*W-1 : e*W].
- `row_sum` output `SUM_WIDTH`: signed sum of the row elements.
- `row_sqsum` output `SQ_WIDTH`: sum of the squared row elements.
- `row_valid_n` output 1: row outputs valid, active-low.
- `row_ready_n` input 1: downstream accepts the row, active-low. Tie it low for the layernorm core, which has no ready.
- `err_frame` output 1: sticky framing error.

## Operation
- States: FILL and HOLD. Reset state is FILL.
- Beat accept condition: `in_valid_n`==0 && `in_ready_n`==0.
- `in_ready_n` = !`rst_n` | (state==HOLD). It is combinational from state.
- FILL, accepted beat k (beat counter value k):
  - Lane j is written to element k*`LANES`+j.
  - `row_sum` += sign-extended sum of the lanes.
  - `row_sqsum` += sum of the lane squares.
  - The counter increments.
- FILL, beat k = BEATS-1 accepted: the counter wraps to 0 and the state goes to HOLD on the next edge.
- HOLD:
  - `row_valid_n`=0.
  - `row_data`, `row_sum` and `row_sqsum` are frozen.
  - Input beats are not accepted.
- HOLD with `row_ready_n`==0: transfer. On the next edge the state goes to FILL, `row_valid_n`=1, and both accumulators clear to 0.
- `row_data` is not cleared between rows. It is overwritten beat by beat and is meaningful only while `row_valid_n`=0.
- Framing: `err_frame` sets when either of these is accepted:
  - `in_last`=1 on beat k≠BEATS-1.
  - `in_last`=0 on beat BEATS-1.
- Row completion is always count-based; `in_last` never shortens or extends a row. `err_frame` clears only on reset.
- Arithmetic widths:
  - The sum is exact in `SUM_WIDTH`; no saturation is needed because the width covers worst case.
  - Squares are exact 2W-bit values, accumulated in `SQ_WIDTH`.
  - No rounding anywhere.

## Timing
- Reset values:
  - `row_valid_n`=1, `in_ready_n`=1 (while `rst_n`=0).
  - `row_data`=0, `row_sum`=0, `row_sqsum`=0, `err_frame`=0.
  - State FILL, beat counter 0.
- Reset mid-row: the partial row is discarded. Counter and accumulators return to 0.
- Input bubbles (`in_valid_n`=1 in FILL) stall the counter and accumulators. The result must not change.
- Latency: last beat accepted at edge t, then `row_valid_n`=0 in the cycle after t, with final sums visible.
- Minimum row period is BEATS+1 cycles: BEATS fill cycles plus one HOLD cycle when `row_ready_n` is already low.
- No beat is accepted in the transfer cycle. The first beat of the next row is accepted at the earliest one cycle after the transfer.
- With `row_ready_n` tied low, `row_valid_n` is a one-cycle low pulse per row.
- Backpressure: HOLD persists indefinitely while `row_ready_n`=1. All outputs stay stable and `in_ready_n`=1.

## Test plan
- Reset: assert `rst_n`=0 for 3 cycles mid-stream. Then `row_valid_n`=1, `in_ready_n`=1, `row_sum`=0, `row_sqsum`=0, `err_frame`=0. After release, `in_ready_n`=0 on the next cycle.
- Basic row (`INPUT_NUM`=16, `LANES`=8):
  - Stimulus: elements 1..16 in 2 back-to-back beats, `in_last` on beat 1, `row_ready_n`=0.
  - Response: `row_valid_n` low for exactly 1 cycle, one cycle after the second beat; element e = e+1; `row_sum`=136, `row_sqsum`=1496; `err_frame`=0.
- Signed extreme: all 16 elements = -128. Then `row_sum`=-2048 (12-bit) and `row_sqsum`=262144 (20-bit).
- Backpressure: hold `row_ready_n`=1 for 5 cycles after completion while driving `in_valid_n`=0.
  - Outputs stay frozen, `in_ready_n`=1, and no beat is consumed.
  - On release, the next row's first beat is accepted two cycles later and yields correct sums.
- Bubbles: insert 3 idle cycles between beats. The sums and `row_data` are identical to the basic row case.
- Framing: assert `in_last` on beat 0. `err_frame` goes to 1 and stays 1, the row still completes after 2 beats with correct sums, and only reset clears `err_frame`.
